// File: rtl/down_counter_timer_if.sv
// Control and status bundle for down_counter_timer: the master drives the
// controls and observes the count and status flags.
interface down_counter_timer_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             busy;
    logic             done;

    modport master (
        output clr, load, load_val, en, auto_reload,
        input  count, tc, busy, done
    );

    modport slave (
        input  clr, load, load_val, en, auto_reload,
        output count, tc, busy, done
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down counter with terminal-count pulse and optional auto-reload.
// Serves as an interval timer (one-shot) or a modulo-N clock-enable divider.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_b,
    down_counter_timer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_q, count_nxt;
    logic [WIDTH-1:0] reload_q, reload_nxt;
    logic             tc_q, tc_nxt;
    logic             busy_q, done_q;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            count_q  <= count_nxt;
            reload_q <= reload_nxt;
            tc_q     <= tc_nxt;
            // Status flags are decoded from the next state so they line up with it
            busy_q   <= (state_nxt == RUN);
            done_q   <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt  = state;
        count_nxt  = count_q;
        reload_nxt = reload_q;
        tc_nxt     = 1'b0;

        if (bus.clr) begin
            state_nxt = IDLE;
            count_nxt = ZERO;
        end else if (bus.load) begin
            count_nxt  = bus.load_val;
            reload_nxt = bus.load_val;
            state_nxt  = (bus.load_val != ZERO) ? RUN : IDLE;
        end else if (state == RUN && bus.en) begin
            if (count_q == ONE) begin
                tc_nxt = 1'b1;
                if (bus.auto_reload) begin
                    count_nxt = reload_q;
                end else begin
                    count_nxt = ZERO;
                    state_nxt = DONE;
                end
            end else begin
                count_nxt = count_q - ONE;
            end
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_down_counter_timer.sv
// Directed testbench for down_counter_timer with hand-computed expectations.
module tb_down_counter_timer;
    logic clk;
    logic reset_b;
    int   checks;
    int   errors;
    int   tc_cnt;
    int   en_v  [6];
    int   cnt_v [6];

    down_counter_timer_if #(.WIDTH(4)) bus ();

    down_counter_timer #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int c, input int t, input int b, input int d);
        chk({tag, ".count"}, int'(bus.count), c);
        chk({tag, ".tc"},    int'(bus.tc),    t);
        chk({tag, ".busy"},  int'(bus.busy),  b);
        chk({tag, ".done"},  int'(bus.done),  d);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_b         = 1'b0;
        bus.clr         = 1'b0;
        bus.load        = 1'b0;
        bus.load_val    = 4'd0;
        bus.en          = 1'b0;
        bus.auto_reload = 1'b0;

        // Reset state
        repeat (3) step();
        chk_all("reset", 0, 0, 0, 0);
        reset_b = 1'b1;
        step();

        // Reset mid-run: load 9, three decrements, then async reset between edges
        bus.load = 1'b1; bus.load_val = 4'd9; bus.en = 1'b1;
        step();
        chk_all("rst_run_load", 9, 0, 1, 0);
        bus.load = 1'b0;
        repeat (3) step();
        chk("rst_run_pre.count", int'(bus.count), 6);
        #2 reset_b = 1'b0;
        #1;
        chk_all("rst_run_async", 0, 0, 0, 0);
        step();
        reset_b = 1'b1;
        repeat (3) step();
        chk_all("rst_run_after", 0, 0, 0, 0);

        // One-shot from 5
        bus.load = 1'b1; bus.load_val = 4'd5; bus.auto_reload = 1'b0; bus.en = 1'b1;
        step();
        chk_all("os_load", 5, 0, 1, 0);
        bus.load = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            step();
            chk_all("os_dec", i, 0, 1, 0);
        end
        step();
        chk_all("os_tc", 0, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk_all("os_hold", 0, 0, 0, 1);
        end

        // Auto-reload divider by 3 over 12 enabled cycles
        bus.load = 1'b1; bus.load_val = 4'd3; bus.auto_reload = 1'b1; bus.en = 1'b1;
        step();
        chk_all("ar_load", 3, 0, 1, 0);
        bus.load = 1'b0;
        tc_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("ar.count", int'(bus.count), (i % 3 == 0) ? 3 : 3 - (i % 3));
            chk("ar.tc",    int'(bus.tc),    (i % 3 == 0) ? 1 : 0);
            chk("ar.busy",  int'(bus.busy),  1);
            if (bus.tc) tc_cnt++;
        end
        chk("ar.tc_pulses", tc_cnt, 4);

        // Enable gating: load 4, en 1,0,0,1,1,1
        en_v  = '{1, 0, 0, 1, 1, 1};
        cnt_v = '{3, 3, 3, 2, 1, 0};
        bus.load = 1'b1; bus.load_val = 4'd4; bus.auto_reload = 1'b0; bus.en = 1'b1;
        step();
        chk_all("eg_load", 4, 0, 1, 0);
        bus.load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.en = en_v[i][0];
            step();
            chk("eg.count", int'(bus.count), cnt_v[i]);
            chk("eg.tc",    int'(bus.tc),    (i == 5) ? 1 : 0);
        end
        chk("eg.done", int'(bus.done), 1);

        // clr and load together: clr wins
        bus.clr = 1'b1; bus.load = 1'b1; bus.load_val = 4'd7; bus.en = 1'b1;
        step();
        chk_all("clr_load", 0, 0, 0, 0);
        bus.clr = 1'b0; bus.load = 1'b0;
        // IDLE ignores en
        repeat (3) step();
        chk_all("idle_en", 0, 0, 0, 0);

        // Reload during RUN at count 2, then 15 cycles to terminal count
        bus.load = 1'b1; bus.load_val = 4'd5; bus.en = 1'b1;
        step();
        bus.load = 1'b0;
        repeat (3) step();
        chk("mid.count", int'(bus.count), 2);
        bus.load = 1'b1; bus.load_val = 4'd15;
        step();
        chk_all("mid_load15", 15, 0, 1, 0);
        bus.load = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            step();
            chk("max.count", int'(bus.count), 15 - i);
            chk("max.tc",    int'(bus.tc),    0);
        end
        step();
        chk_all("max_tc", 0, 1, 0, 1);

        // Zero load goes to IDLE with no tc
        bus.load = 1'b1; bus.load_val = 4'd0; bus.en = 1'b1;
        step();
        chk_all("zero_load", 0, 0, 0, 0);
        bus.load = 1'b0;
        step();
        chk_all("zero_after", 0, 0, 0, 0);

        // clr mid-count
        bus.load = 1'b1; bus.load_val = 4'd6;
        step();
        bus.load = 1'b0;
        step();
        chk("clr_mid_pre.count", int'(bus.count), 5);
        bus.clr = 1'b1;
        step();
        chk_all("clr_mid", 0, 0, 0, 0);
        bus.clr = 1'b0;

        // Auto-reload switched off before the second terminal count
        bus.load = 1'b1; bus.load_val = 4'd2; bus.auto_reload = 1'b1; bus.en = 1'b1;
        step();
        chk_all("aro_load", 2, 0, 1, 0);
        bus.load = 1'b0;
        step();
        chk_all("aro_1", 1, 0, 1, 0);
        step();
        chk_all("aro_tc1", 2, 1, 1, 0);
        bus.auto_reload = 1'b0;
        step();
        chk_all("aro_2", 1, 0, 1, 0);
        step();
        chk_all("aro_tc2", 0, 1, 0, 1);
        step();
        chk_all("aro_done", 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
